pkt_source_tx: RTL and testbench
================================

PKT_SOURCE_TX -- requirements
Module: pkt_source_tx

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: wr_en  in  1  payload-buffer write strobe.
REQ-004 SHALL have: wr_data  in  8  payload byte to write.
REQ-005 SHALL have: start  in  1  request to transmit the buffered packet.
REQ-006 SHALL have: dest_addr  in  2  destination port, values 0..2 legal.
REQ-007 SHALL have: busy  in  1  router input stall, presented byte not taken.
REQ-008 SHALL have: pkt_data  out  8  byte driven to the router data input.
REQ-009 SHALL have: pkt_valid  out  1  high for header/payload, low for parity.
REQ-010 SHALL have: buf_count  out  6  bytes currently buffered.
REQ-011 SHALL have: full  out  1  buf_count==63.
REQ-012 SHALL have: tx_active  out  1  packet in progress.
REQ-013 SHALL have: done  out  1  one-cycle pulse after parity accepted.
REQ-014 SHALL have: err  out  1  one-cycle pulse on rejected start or write.

Function
REQ-015 SHALL hold payload in an internal 64x8 buffer; bytes 0..buf_count-1 are sent in write order.
REQ-016 SHALL, in IDLE, write wr_data at index buf_count and increment buf_count on wr_en when buf_count<63.
REQ-017 SHALL ignore wr_en when full or when tx_active, and pulse err the next cycle.
REQ-018 SHALL use FSM states IDLE, HEADER, PAYLOAD, PARITY, DONE.
REQ-019 SHALL accept start in IDLE only when dest_addr!=3 and buf_count!=0 and go to HEADER; otherwise stay in IDLE and pulse err.
REQ-020 SHALL, when wr_en and start are asserted in the same IDLE cycle, apply the write first and include that byte in the packet.
REQ-021 SHALL drive header {buf_count[5:0], dest_addr[1:0]} with pkt_valid=1 in HEADER, the first cycle after start is accepted.
REQ-022 SHALL treat the presented byte as accepted at any rising edge where busy==0 and advance to the next byte.
REQ-023 SHALL hold pkt_data, pkt_valid and state unchanged at every edge where busy==1, for any number of cycles.
REQ-024 SHALL drive payload bytes in PAYLOAD with pkt_valid=1, one per accepted edge, with no gaps.
REQ-025 SHALL drive, in PARITY, the XOR of the header and all payload bytes, with pkt_valid=0.
REQ-026 SHALL, on parity acceptance, enter DONE for one cycle: done=1, pkt_data=0, buf_count cleared; then return to IDLE.
REQ-027 SHALL keep tx_active=1 in HEADER, PAYLOAD and PARITY; otherwise 0.
REQ-028 SHALL ignore start while tx_active and SHALL NOT raise err for it.
REQ-029 SHALL register all outputs; pkt_data=0 and pkt_valid=0 whenever not in HEADER, PAYLOAD or PARITY.

Reset
REQ-030 SHALL on reset force IDLE, buf_count=0, pkt_data=0, pkt_valid=0, tx_active=0, done=0, err=0, independent of clock.
REQ-031 SHALL abort any packet in flight on reset, discard buffer contents and issue no parity byte.
REQ-032 SHALL leave buffer RAM contents unspecified after reset.

Configuration
REQ-033 SHALL, with PKT_TX_PARITY_INJ_EN defined, add input corrupt_parity (1 bit), sampled when start is accepted; when set, parity bit 0 is inverted for that packet.
REQ-034 SHALL, without PKT_TX_PARITY_INJ_EN, have no corrupt_parity port and always send correct parity.

Verification
REQ-035 SHALL cover: write 0x04,0x05,0x06; start with dest_addr=2; busy=0 -> pkt_data 0x0E,0x04,0x05,0x06 with pkt_valid=1, then 0x09 with pkt_valid=0, then done pulse and buf_count=0.
REQ-036 SHALL cover: same packet with busy=1 for 3 cycles while byte 0x05 is driven -> 0x05 held for 4 cycles, remaining sequence unchanged.
REQ-037 SHALL cover: start with dest_addr=3, or with buf_count=0 -> err pulse, pkt_valid stays 0, FSM stays IDLE.
REQ-038 SHALL cover: 64 writes -> full=1 and buf_count=63 after the 63rd write, err on the 64th; header 0xFC|addr.
REQ-039 SHALL cover: reset asserted mid-PAYLOAD -> outputs zero immediately; a new 1-byte packet 0xAA to addr 0 then yields 0x04,0xAA,0xAE.
REQ-040 SHALL cover, with PKT_TX_PARITY_INJ_EN defined and corrupt_parity=1: REQ-035 stimulus -> parity byte 0x08.

Source files
------------

// File: rtl/pkt_source_tx.sv
// pkt_source_tx
// Packet source for a router input port. Payload bytes are written into a
// 64x8 buffer while idle. A start request sends a header byte
// {byte_count, dest_addr}, then the buffered payload in write order, then an
// XOR parity byte (pkt_valid low). The router stalls transfers with busy.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous active-high reset
//   wr_en/wr_data  payload-buffer write strobe and byte
//   start          transmit request, dest_addr 0..2 legal
//   busy           router stall: presented byte not taken this edge
//   pkt_data       byte presented to the router
//   pkt_valid      1 for header/payload, 0 for parity
//   buf_count      bytes currently buffered; full when 63
//   tx_active      packet in progress (HEADER, PAYLOAD, PARITY)
//   done           one-cycle pulse after parity is accepted
//   err            one-cycle pulse on a rejected start or write
//
// Optional build macro PKT_TX_PARITY_INJ_EN adds input corrupt_parity,
// sampled with an accepted start; when set, parity bit 0 of that packet is
// inverted.
module pkt_source_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic       busy,
`ifdef PKT_TX_PARITY_INJ_EN
  input  logic       corrupt_parity,
`endif
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic [5:0] buf_count,
  output logic       full,
  output logic       tx_active,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Running parity update: one byte folded into the accumulator.
  function automatic logic [7:0] par_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [7:0] mem_q [64];

  logic [2:0] state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       full_q, full_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       inj_q, inj_d;

  logic       wr_ok_s;
  logic [5:0] count_eff_s;
  logic [7:0] hdr_s;
  logic [7:0] mem_rd_s;

  // Next-state logic for the transmit FSM and buffer bookkeeping.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    par_d    = par_q;
    data_d   = data_q;
    valid_d  = valid_q;
    full_d   = full_q;
    active_d = active_q;
    inj_d    = inj_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mem_rd_s = mem_q[idx_q];

    // A write is taken only in IDLE with room left; the same-cycle count is
    // what a simultaneous start sees, so the new byte joins the packet.
    wr_ok_s     = (state_q == ST_IDLE) && wr_en && (count_q != 6'd63);
    count_eff_s = wr_ok_s ? (count_q + 6'd1) : count_q;
    hdr_s       = {count_eff_s, dest_addr};

    // Rejected writes: buffer full or a packet in flight. Writes during the
    // single DONE cycle are dropped silently.
    if (wr_en && (active_q || (count_q == 6'd63))) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        count_d = count_eff_s;
        full_d  = (count_eff_s == 6'd63);
        if (start) begin
          if ((dest_addr != 2'd3) && (count_eff_s != 6'd0)) begin
            state_d  = ST_HEADER;
            data_d   = hdr_s;
            valid_d  = 1'b1;
            active_d = 1'b1;
            par_d    = hdr_s;
            idx_d    = 6'd0;
`ifdef PKT_TX_PARITY_INJ_EN
            inj_d    = corrupt_parity;
`else
            inj_d    = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        if (!busy) begin
          if (idx_q != count_q) begin
            state_d = ST_PAYLOAD;
            data_d  = mem_rd_s;
            par_d   = par_fold(par_q, mem_rd_s);
            idx_d   = idx_q + 6'd1;
          end else begin
            state_d = ST_PARITY;
            data_d  = par_q ^ {7'd0, inj_q};
            valid_d = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          state_d  = ST_DONE;
          data_d   = 8'd0;
          valid_d  = 1'b0;
          active_d = 1'b0;
          done_d   = 1'b1;
          count_d  = 6'd0;
          full_d   = 1'b0;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        data_d   = 8'd0;
        valid_d  = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 6'd0;
      idx_q    <= 6'd0;
      par_q    <= 8'd0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      inj_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      inj_q    <= inj_d;
    end
  end

  // Payload RAM: no reset, contents are don't-care until rewritten.
  always_ff @(posedge clock) begin
    if (wr_ok_s) begin
      mem_q[count_q] <= wr_data;
    end
  end

  assign pkt_data  = data_q;
  assign pkt_valid = valid_q;
  assign buf_count = count_q;
  assign full      = full_q;
  assign tx_active = active_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pkt_source_tx.sv
module tb_pkt_source_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic       busy = 1'b0;
  logic       corrupt_parity = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic [5:0] buf_count;
  logic       full;
  logic       tx_active;
  logic       done;
  logic       err;

  pkt_source_tx dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .start(start),
    .dest_addr(dest_addr),
    .busy(busy),
`ifdef PKT_TX_PARITY_INJ_EN
    .corrupt_parity(corrupt_parity),
`endif
    .pkt_data(pkt_data),
    .pkt_valid(pkt_valid),
    .buf_count(buf_count),
    .full(full),
    .tx_active(tx_active),
    .done(done),
    .err(err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: buffered bytes, expected byte stream {valid,data},
  // and a coarse packet phase (0 idle, 1 transmitting, 2 done cycle).
  logic [7:0] model_buf[$];
  logic [8:0] exp_q[$];
  int         phase = 0;
  int         remaining = 0;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: while a packet is in flight the presented byte must be the head
  // of the expected stream; it is consumed only on an edge with busy low.
  always @(negedge clock) begin
    if (tx_active) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", int'({pkt_valid, pkt_data}), 512);
      end else begin
        chk("pkt_byte", int'({pkt_valid, pkt_data}), int'(exp_q[0]));
        if (!busy) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_outputs", int'({pkt_valid, pkt_data}), 0);
    end
  end

  task automatic step(input logic wr, input logic [7:0] d, input logic st,
                      input logic [1:0] ds, input logic bz);
    logic       e_err;
    logic [7:0] hdr;
    logic [7:0] par;
    int         sz;
    wr_en = wr; wr_data = d; start = st; dest_addr = ds; busy = bz;
    e_err = 1'b0;
    if (phase == 0) begin
      if (wr) begin
        if (model_buf.size() < 63) model_buf.push_back(d);
        else e_err = 1'b1;
      end
      if (st) begin
        sz = model_buf.size();
        if (ds != 2'd3 && sz != 0) begin
          hdr = {sz[5:0], ds};
          exp_q.push_back({1'b1, hdr});
          par = hdr;
          foreach (model_buf[i]) begin
            exp_q.push_back({1'b1, model_buf[i]});
            par = par ^ model_buf[i];
          end
`ifdef PKT_TX_PARITY_INJ_EN
          if (corrupt_parity) par[0] = ~par[0];
`endif
          exp_q.push_back({1'b0, par});
          remaining = sz + 2;
          phase = 1;
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (phase == 1) begin
      if (wr) e_err = 1'b1;
      if (!bz) begin
        remaining--;
        if (remaining == 0) begin
          phase = 2;
          model_buf.delete();
        end
      end
    end else begin
      phase = 0;
    end
    @(posedge clock);
    #1;
    sz = model_buf.size();
    chk("err", int'(err), int'(e_err));
    chk("done", int'(done), (phase == 2) ? 1 : 0);
    chk("buf_count", int'(buf_count), sz);
    chk("full", int'(full), (sz == 63) ? 1 : 0);
    chk("tx_active", int'(tx_active), (phase == 1) ? 1 : 0);
  endtask

  task automatic finish_tx();
    for (int k = 0; k < 300 && phase != 0; k++) step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    chk("tx_completed", phase, 0);
  endtask

  task automatic write3_start2();
    step(1'b1, 8'h04, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h05, 1'b0, 2'd0, 1'b0);
    step(1'b1, 8'h06, 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
  endtask

  initial begin
    // Reset values, checked while reset is still asserted.
    #3;
    chk("rst_pkt_data", int'(pkt_data), 0);
    chk("rst_pkt_valid", int'(pkt_valid), 0);
    chk("rst_buf_count", int'(buf_count), 0);
    chk("rst_flags", int'({full, tx_active, done, err}), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic packet: 0x0E,0x04,0x05,0x06 then parity 0x09.
    write3_start2();
    finish_tx();
    step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);

    // Same packet with a 3-cycle stall while 0x05 is presented.
    write3_start2();
    step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 8'h77, 1'b1, 2'd1, 1'b1);
    finish_tx();

    // Rejected starts: empty buffer, then illegal destination.
    step(1'b0, 8'd0, 1'b1, 2'd1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 2'd3, 1'b0);
    // Write and start together: the new byte joins the packet.
    step(1'b1, 8'h5A, 1'b1, 2'd0, 1'b0);
    finish_tx();

    // Fill the buffer: 63 writes fit, the 64th is rejected; header 0xFD.
    for (int k = 0; k < 64; k++) step(1'b1, 8'(k * 7 + 1), 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 2'd1, 1'b0);
    finish_tx();

    // Reset in the middle of the payload, then a 1-byte packet 0x04,0xAA,0xAE.
    write3_start2();
    step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    #2;
    chk("midrst_pkt", int'({pkt_valid, pkt_data}), 0);
    chk("midrst_buf_count", int'(buf_count), 0);
    chk("midrst_flags", int'({full, tx_active, done, err}), 0);
    exp_q.delete();
    model_buf.delete();
    phase = 0;
    remaining = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    step(1'b1, 8'hAA, 1'b0, 2'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 2'd0, 1'b0);
    finish_tx();

`ifdef PKT_TX_PARITY_INJ_EN
    // Parity injection: same 3-byte packet, parity becomes 0x08.
    corrupt_parity = 1'b1;
    write3_start2();
    corrupt_parity = 1'b0;
    finish_tx();
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic       r_wr;
      logic       r_st;
      logic       r_bz;
      logic [1:0] r_ds;
      r_ds = 2'($urandom_range(0, 3));
      r_bz = ($urandom_range(0, 2) == 0);
      if (phase == 1) begin
        r_wr = ($urandom_range(0, 3) == 0);
        r_st = ($urandom_range(0, 3) == 0);
      end else if (phase == 2) begin
        r_wr = 1'b0;
        r_st = ($urandom_range(0, 1) == 0);
      end else begin
        r_wr = ($urandom_range(0, 1) == 0);
        r_st = ($urandom_range(0, 5) == 0);
      end
      step(r_wr, 8'($urandom), r_st, r_ds, r_bz);
    end
    finish_tx();
    step(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    chk("stream_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
